sample_pacer: RTL and testbench
===============================

SAMPLE_PACER -- requirements
Module: sample_pacer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning sample FIFO depth (power of two, >= 2).
REQ-002 The block SHALL have parameter GAP, default 6, meaning the minimum number of clk cycles from one data_en pulse to the next; 6 matches the downstream FIR's per-sample compute time.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, signed 8 bits: upstream sample.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept a sample this cycle.
REQ-008 The block SHALL have port data, output, signed 8 bits: sample presented to the FIR.
REQ-009 The block SHALL have port data_en, output, 1 bit: one-cycle strobe marking a new sample on data.
REQ-010 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag for a sample offered while the FIFO was full.

Function
REQ-012 The block SHALL accept (push) a sample when in_valid && in_ready at a rising edge.
REQ-013 The block SHALL drive in_ready = (level != DEPTH), derived from registered state only.
REQ-014 A pop in the same cycle SHALL NOT make in_ready high when the FIFO is full.
REQ-015 The block SHALL keep a gap counter; when the gap counter is 0 and the FIFO is non-empty, it SHALL pop the head into the data register, assert data_en for exactly one cycle, and load the gap counter with GAP-1.
REQ-016 The gap counter SHALL decrement by 1 per cycle while non-zero, so consecutive data_en pulses are exactly GAP cycles apart while samples remain queued.
REQ-017 data SHALL be registered and SHALL hold the last issued sample between strobes.
REQ-018 data_en SHALL be 0 on every cycle not covered by REQ-015.
REQ-019 Latency: a sample pushed at edge t into an empty FIFO with the gap counter at 0 SHALL appear with data_en=1 after edge t+1; there is no combinational fall-through.
REQ-020 On a simultaneous push and pop, level SHALL be unchanged and both operations SHALL complete.
REQ-021 When the FIFO is empty, no strobe SHALL be issued; the gap counter SHALL still run down to 0 and then hold.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH, and FIFO order SHALL be preserved across the wrap.
REQ-023 in_valid && !in_ready SHALL set overflow to 1; the sample SHALL be discarded; overflow SHALL clear only on rst.
REQ-024 Samples SHALL pass through bit-exact: no sign change, truncation or reordering.

Reset
REQ-025 While rst=1 at an edge, the block SHALL empty the FIFO (pointers 0, level 0) and clear data to 0, data_en to 0, the gap counter to 0 and overflow to 0.
REQ-026 in_ready SHALL be 1 on the first cycle after reset.
REQ-027 A reset mid-operation SHALL drop queued samples, and no strobe SHALL be issued in the cycle following the reset edge.
REQ-028 FIFO storage contents need not be reset.

Structure
REQ-029 Package pacer_pkg SHALL hold SAMPLE_W=8, DEFAULT_DEPTH=8, DEFAULT_GAP=6 and the level-width function.
REQ-030 The FIFO SHALL be one sub-module, sync_fifo (push/pop/full/empty/level, parameterised on width and depth).
REQ-031 The pacing counter and output registers SHALL live in sample_pacer.

Verification
REQ-032 Single sample: push 0x7F into an idle block -> data_en=1 with data=0x7F exactly one cycle after the push; level returns to 0.
REQ-033 Burst: push 8 samples (-128, -1, 0, 1, 2, 3, 4, 127) back-to-back -> 8 strobes spaced exactly 6 cycles apart, in the same order, values bit-exact; in_ready stays 1.
REQ-034 Overflow: with the FIFO full (level=8), drive in_valid with 0x55 -> in_ready=0, 0x55 is never emitted, overflow=1 and stays 1 until rst.
REQ-035 Wrap-around: stream 20 samples at one push per 6 cycles, then 8-sample bursts -> output order matches input order across the pointer wrap; level never exceeds 8.
REQ-036 Reset mid-stream: assert rst with level=5 and the gap counter at 3 -> next cycle level=0, data=0, data_en=0, overflow=0, in_ready=1; no strobe until new pushes arrive.
REQ-037 Simultaneous push and pop at level=3 -> level stays 3 and the pushed value emerges in order.

Source files
------------

// File: rtl/pacer_pkg.sv
// Shared constants and helpers for the sample pacer: sample width, default sizing and the
// occupancy-counter width function.
package pacer_pkg;

  localparam int unsigned SAMPLE_W      = 8;
  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_GAP   = 6;

  // Occupancy must represent 0..depth inclusive, hence the extra bit.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; the head is read combinationally from storage
// so the consumer can register it on the pop edge.
module sync_fifo
  import pacer_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_q];
  assign level   = level_q;

  // Pointers are exactly AW bits, so wrap modulo DEPTH is implicit for power-of-two depths.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/sample_pacer.sv
// Buffers upstream samples and releases them to the FIR no more often than once every GAP
// cycles, as a registered sample plus a one-cycle data_en strobe.
module sample_pacer
  import pacer_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned GAP   = DEFAULT_GAP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [SAMPLE_W-1:0] data,
  output logic                       data_en,
  output logic [level_w(DEPTH)-1:0]  level,
  output logic                       overflow
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GapReload = GW'(GAP - 1);

  logic [SAMPLE_W-1:0]        fifo_rdata;
  logic                       fifo_full, fifo_empty;
  logic                       push, pop;
  logic [GW-1:0]              gap_q, gap_d;
  logic signed [SAMPLE_W-1:0] data_q, data_d;
  logic                       data_en_q, data_en_d;
  logic                       overflow_q, overflow_d;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Full comes from the registered level, so a same-cycle pop never opens in_ready.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (gap_q == '0) && !fifo_empty;

  always_comb begin
    gap_d      = gap_q;
    data_d     = data_q;
    data_en_d  = 1'b0;
    overflow_d = overflow_q;
    if (pop) begin
      gap_d     = GapReload;
      data_d    = fifo_rdata;
      data_en_d = 1'b1;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
    if (in_valid && !in_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q      <= '0;
      data_q     <= '0;
      data_en_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      gap_q      <= gap_d;
      data_q     <= data_d;
      data_en_q  <= data_en_d;
      overflow_q <= overflow_d;
    end
  end

  assign data     = data_q;
  assign data_en  = data_en_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sample_pacer.sv
// Randomised self-checking bench for sample_pacer against a queue-and-timestamp model.
module tb_sample_pacer;

  localparam int DEPTH = 8;
  localparam int GAP   = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] data;
  logic              data_en;
  logic [3:0]        level;
  logic              overflow;

  sample_pacer #(
    .DEPTH (DEPTH),
    .GAP   (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .data_en  (data_en),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Model: pending samples, edge index of the last issue, expected output registers.
  logic signed [7:0] q[$];
  int                cyc      = 0;
  int                last_pop = -1000;
  logic signed [7:0] m_data   = 8'sd0;
  logic              m_en     = 1'b0;
  logic              m_ovf    = 1'b0;
  int                n_vec    = 0;
  int                n_err    = 0;

  // Drives one cycle and advances the model: an issue may occur at an edge when something
  // was queued before that edge and at least GAP edges have passed since the previous issue.
  task automatic tick(input logic v, input logic signed [7:0] d, input logic r);
    bit pop_now, full_now;
    in_valid = v;
    in_data  = d;
    rst      = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      m_data   = 8'sd0;
      m_en     = 1'b0;
      m_ovf    = 1'b0;
      last_pop = -1000;
    end else begin
      pop_now  = (q.size() > 0) && (cyc - last_pop >= GAP);
      full_now = (q.size() == DEPTH);
      if (v && full_now) m_ovf = 1'b1;
      m_en = pop_now;
      if (pop_now) begin
        m_data   = q.pop_front();
        last_pop = cyc;
      end
      if (v && !full_now) q.push_back(d);
    end
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'sd0, 1'b0);
  endtask

  task automatic test_reset;
    tick(1'b0, 8'sd0, 1'b1);
    tick(1'b0, 8'sd0, 1'b1);
    n_vec++;
    if (level !== 4'd0 || in_ready !== 1'b1 || data !== 8'sd0 || data_en !== 1'b0 ||
        overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got level=%0d rdy=%b data=%0d en=%b ovf=%b want 0 1 0 0 0",
               level, in_ready, data, data_en, overflow);
    end
  endtask

  task automatic test_single;
    idle(GAP);
    tick(1'b1, 8'sh7F, 1'b0);
    n_vec++;
    if (data_en !== 1'b0 || level !== 4'd1) begin
      n_err++;
      $display("FAIL single_push: got en=%b level=%0d want en=0 level=1", data_en, level);
    end
    tick(1'b0, 8'sd0, 1'b0);
    n_vec++;
    if (data_en !== 1'b1 || data !== 8'sh7F || data_en !== m_en || data !== m_data) begin
      n_err++;
      $display("FAIL single_strobe: got en=%b data=%0d want en=1 data=127", data_en, data);
    end
    tick(1'b0, 8'sd0, 1'b0);
    n_vec++;
    if (level !== 4'd0 || data_en !== 1'b0 || data !== 8'sh7F) begin
      n_err++;
      $display("FAIL single_after: got level=%0d en=%b data=%0d want 0 0 127",
               level, data_en, data);
    end
  endtask

  task automatic test_burst;
    logic signed [7:0] burst[8];
    logic signed [7:0] got[$];
    int                when[$];
    burst = '{8'sh80, 8'shFF, 8'sh00, 8'sh01, 8'sh02, 8'sh03, 8'sh04, 8'sh7F};
    idle(60);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL burst_ready: push %0d got in_ready=%b want 1", i, in_ready);
      end
      tick(1'b1, burst[i], 1'b0);
      if (data_en === 1'b1) begin got.push_back(data); when.push_back(cyc); end
    end
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 8'sd0, 1'b0);
      n_vec++;
      if (data_en !== m_en || data !== m_data || level !== 4'(q.size())) begin
        n_err++;
        $display("FAIL burst_cycle: cyc=%0d got en=%b data=%0d level=%0d want %b %0d %0d",
                 cyc, data_en, data, level, m_en, m_data, q.size());
      end
      if (data_en === 1'b1) begin got.push_back(data); when.push_back(cyc); end
    end
    n_vec++;
    if (got.size() != 8) begin
      n_err++;
      $display("FAIL burst_count: got %0d strobes want 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (got[i] !== burst[i]) begin
          n_err++;
          $display("FAIL burst_value: idx %0d got %0d want %0d", i, got[i], burst[i]);
        end
        if (i > 0) begin
          n_vec++;
          if (when[i] - when[i-1] != GAP) begin
            n_err++;
            $display("FAIL burst_spacing: idx %0d got %0d cycles want %0d",
                     i, when[i] - when[i-1], GAP);
          end
        end
      end
    end
  endtask

  task automatic test_overflow;
    logic signed [7:0] d;
    idle(60);
    for (int i = 0; i < 30 && in_ready === 1'b1; i++) begin
      d = 8'($urandom);
      if (d == 8'sh55) d = 8'sh54;
      tick(1'b1, d, 1'b0);
    end
    n_vec++;
    if (in_ready !== 1'b0 || level !== 4'd8) begin
      n_err++;
      $display("FAIL ovf_fill: got in_ready=%b level=%0d want 0 8", in_ready, level);
    end
    tick(1'b1, 8'sh55, 1'b0);
    n_vec++;
    if (overflow !== 1'b1 || overflow !== m_ovf) begin
      n_err++;
      $display("FAIL ovf_flag: got %b want 1", overflow);
    end
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 8'sd0, 1'b0);
      n_vec++;
      if (data_en !== m_en || data !== m_data || overflow !== 1'b1 ||
          (data_en === 1'b1 && data === 8'sh55)) begin
        n_err++;
        $display("FAIL ovf_drain: cyc=%0d got en=%b data=%0d ovf=%b want %b %0d 1",
                 cyc, data_en, data, overflow, m_en, m_data);
      end
    end
    tick(1'b0, 8'sd0, 1'b1);
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_wrap;
    idle(GAP);
    for (int s = 0; s < 20 + 16; s++) begin
      tick(1'b1, 8'($urandom), 1'b0);
      // After the paced phase, two 8-sample bursts each followed by a full drain.
      if (s < 20) idle(GAP - 1);
      else if (s == 27 || s == 35) idle(50);
      n_vec++;
      if (data_en !== m_en || data !== m_data || level !== 4'(q.size()) ||
          level > 4'd8 || overflow !== m_ovf) begin
        n_err++;
        $display("FAIL wrap: cyc=%0d got en=%b data=%0d level=%0d ovf=%b want %b %0d %0d %b",
                 cyc, data_en, data, level, overflow, m_en, m_data, q.size(), m_ovf);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 8'sd0, 1'b0);
      n_vec++;
      if (data_en !== m_en || data !== m_data || level !== 4'(q.size())) begin
        n_err++;
        $display("FAIL wrap_tail: cyc=%0d got en=%b data=%0d level=%0d want %b %0d %0d",
                 cyc, data_en, data, level, m_en, m_data, q.size());
      end
    end
  endtask

  task automatic test_reset_mid;
    idle(60);
    for (int i = 0; i < 7; i++) tick(1'b1, 8'($urandom), 1'b0);
    idle(3);
    n_vec++;
    if (level !== 4'd5 || level !== 4'(q.size())) begin
      n_err++;
      $display("FAIL rstmid_setup: got level=%0d want 5", level);
    end
    tick(1'b0, 8'sd0, 1'b1);
    n_vec++;
    if (level !== 4'd0 || data !== 8'sd0 || data_en !== 1'b0 || overflow !== 1'b0 ||
        in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_state: got level=%0d data=%0d en=%b ovf=%b rdy=%b want 0 0 0 0 1",
               level, data, data_en, overflow, in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 8'sd0, 1'b0);
      n_vec++;
      if (data_en !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_quiet: cyc=%0d got en=%b want 0", cyc, data_en);
      end
    end
    tick(1'b1, 8'sh2A, 1'b0);
    tick(1'b0, 8'sd0, 1'b0);
    n_vec++;
    if (data_en !== 1'b1 || data !== 8'sh2A) begin
      n_err++;
      $display("FAIL rstmid_resume: got en=%b data=%0d want 1 42", data_en, data);
    end
  endtask

  task automatic test_simul;
    logic signed [7:0] x;
    logic signed [7:0] last;
    idle(60);
    for (int i = 0; i < 4; i++) tick(1'b1, 8'($urandom), 1'b0);
    idle(3);
    x = 8'($urandom);
    tick(1'b1, x, 1'b0);
    n_vec++;
    if (level !== 4'd3 || data_en !== 1'b1) begin
      n_err++;
      $display("FAIL simul_level: got level=%0d en=%b want 3 1", level, data_en);
    end
    last = 8'sd0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 8'sd0, 1'b0);
      n_vec++;
      if (data_en !== m_en || data !== m_data) begin
        n_err++;
        $display("FAIL simul_drain: cyc=%0d got en=%b data=%0d want %b %0d",
                 cyc, data_en, data, m_en, m_data);
      end
      if (data_en === 1'b1) last = data;
    end
    n_vec++;
    if (last !== x || level !== 4'd0) begin
      n_err++;
      $display("FAIL simul_order: got last=%0d level=%0d want %0d 0", last, level, x);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'sd0;
    test_reset;
    test_single;
    test_burst;
    test_overflow;
    test_wrap;
    test_reset_mid;
    test_simul;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
